// File: rtl/io_tile_cfg_reg.sv
// io_tile_cfg_reg: generation-2 IO tile at the fabric edge.
// Routes interconnect tracks to pads and pads to tracks. Each path can be
// registered or bypassed, and each pad has an output enable. Routing comes from
// a serial configuration shift chain. While config_enable is high, every data
// output and the pad enables are forced low because the chain contents are in flux.
module io_tile_cfg_reg #(
   parameter int IO_PAIRS = 4,
   parameter int IC_PAIRS = 10
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [IO_PAIRS-1:0] data_from_io,
   output logic [IO_PAIRS-1:0] data_to_io,
   output logic [IO_PAIRS-1:0] data_oe_io,
   input  logic [IC_PAIRS-1:0] data_from_ic,
   output logic [IC_PAIRS-1:0] data_to_ic,
   input  logic                config_in,
   output logic                config_out,
   input  logic                config_enable
);

   localparam int OSEL_W   = (IC_PAIRS > 1) ? $clog2(IC_PAIRS) : 1;
   localparam int ISEL_W   = (IO_PAIRS > 1) ? $clog2(IO_PAIRS) : 1;
   localparam int IO_FLD   = OSEL_W + 3;
   localparam int IC_FLD   = ISEL_W + 1;
   localparam int IC_BASE  = IO_PAIRS * IO_FLD;
   localparam int CFG_BITS = IO_PAIRS * IO_FLD + IC_PAIRS * IC_FLD;

   logic [CFG_BITS-1:0] cfg_q, cfg_d;
   logic [IO_PAIRS-1:0] outPipe_q, outPipe_d;
   logic [IO_PAIRS-1:0] inPipe_q, inPipe_d;

   logic [OSEL_W-1:0]   osel [IO_PAIRS];
   logic [IO_PAIRS-1:0] padOe;
   logic [IO_PAIRS-1:0] padOutReg;
   logic [IO_PAIRS-1:0] padInReg;
   logic [ISEL_W-1:0]   isel [IC_PAIRS];
   logic [IC_PAIRS-1:0] trackEn;

   logic [IO_PAIRS-1:0] outSrc;
   logic                outGate;

   // Shift the chain while configuring; hold it otherwise.
   always_comb begin
      cfg_d = cfg_q;
      if (config_enable) begin
         cfg_d = {cfg_q[CFG_BITS-2:0], config_in};
      end
   end

   // Chain storage; reset discards any partially shifted configuration.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cfg_q <= '0;
      end else begin
         cfg_q <= cfg_d;
      end
   end

   assign config_out = cfg_q[CFG_BITS-1];

   // Split the chain into per-pad and per-track fields.
   always_comb begin
      for (int i = 0; i < IO_PAIRS; i++) begin
         osel[i]      = cfg_q[i*IO_FLD +: OSEL_W];
         padOe[i]     = cfg_q[i*IO_FLD + OSEL_W];
         padOutReg[i] = cfg_q[i*IO_FLD + OSEL_W + 1];
         padInReg[i]  = cfg_q[i*IO_FLD + OSEL_W + 2];
      end
      for (int j = 0; j < IC_PAIRS; j++) begin
         isel[j]    = cfg_q[IC_BASE + j*IC_FLD +: ISEL_W];
         trackEn[j] = cfg_q[IC_BASE + j*IC_FLD + ISEL_W];
      end
   end

   // Track-to-pad selection; selector codes beyond the last track give 0.
   always_comb begin
      outSrc = '0;
      for (int i = 0; i < IO_PAIRS; i++) begin
         for (int k = 0; k < IC_PAIRS; k++) begin
            if (osel[i] == OSEL_W'(k)) begin
               outSrc[i] = data_from_ic[k];
            end
         end
      end
   end

   // Pipeline registers capture 0 while configuring so stale data never leaks out.
   always_comb begin
      outPipe_d = config_enable ? '0 : outSrc;
      inPipe_d  = config_enable ? '0 : data_from_io;
   end

   // Per-pad output and input pipeline registers, updated every cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         outPipe_q <= '0;
         inPipe_q  <= '0;
      end else begin
         outPipe_q <= outPipe_d;
         inPipe_q  <= inPipe_d;
      end
   end

   assign outGate = config_enable | reset;

   // Pad outputs and enables, registered or bypassed per pad, gated while configuring.
   always_comb begin
      data_to_io = '0;
      data_oe_io = '0;
      for (int i = 0; i < IO_PAIRS; i++) begin
         if (!outGate) begin
            data_to_io[i] = padOutReg[i] ? outPipe_q[i] : outSrc[i];
            data_oe_io[i] = padOe[i];
         end
      end
   end

   // Pad-to-track selection; latency follows the in_reg bit of the chosen source pad.
   always_comb begin
      data_to_ic = '0;
      for (int j = 0; j < IC_PAIRS; j++) begin
         if (trackEn[j] && !outGate) begin
            for (int p = 0; p < IO_PAIRS; p++) begin
               if (isel[j] == ISEL_W'(p)) begin
                  data_to_ic[j] = padInReg[p] ? inPipe_q[p] : data_from_io[p];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_io_tile_cfg_reg.sv
// tb_io_tile_cfg_reg: directed bench for the IO tile.
// It builds configuration words, shifts them in, and then compares the routed
// outputs against vectors worked out by hand.
module tb_io_tile_cfg_reg;

   localparam int CFG_BITS = 58;

   logic        clock;
   logic        reset;
   logic [3:0]  data_from_io;
   logic [3:0]  data_to_io;
   logic [3:0]  data_oe_io;
   logic [9:0]  data_from_ic;
   logic [9:0]  data_to_ic;
   logic        config_in;
   logic        config_out;
   logic        config_enable;

   int checks;
   int failures;

   typedef struct {
      logic [3:0] io;
      logic [9:0] ic;
      logic [3:0] expToIo;
      logic [3:0] expOe;
      logic [9:0] expToIc;
   } vec_t;

   vec_t vecs[6];

   io_tile_cfg_reg dut (
      .clock         (clock),
      .reset         (reset),
      .data_from_io  (data_from_io),
      .data_to_io    (data_to_io),
      .data_oe_io    (data_oe_io),
      .data_from_ic  (data_from_ic),
      .data_to_ic    (data_to_ic),
      .config_in     (config_in),
      .config_out    (config_out),
      .config_enable (config_enable)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [CFG_BITS-1:0] setIo(input logic [CFG_BITS-1:0] v, input int i,
                                                  input logic inR, input logic outR,
                                                  input logic oe, input logic [3:0] osel);
      logic [CFG_BITS-1:0] r;
      r = v;
      r[i*7 +: 7] = {inR, outR, oe, osel};
      return r;
   endfunction

   function automatic logic [CFG_BITS-1:0] setIc(input logic [CFG_BITS-1:0] v, input int j,
                                                  input logic en, input logic [1:0] isel);
      logic [CFG_BITS-1:0] r;
      r = v;
      r[28 + j*3 +: 3] = {en, isel};
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] io, input logic [9:0] ic);
      data_from_io = io;
      data_from_ic = ic;
   endtask

   task automatic shiftBit(input logic b);
      config_in     = b;
      config_enable = 1'b1;
      tick();
   endtask

   task automatic loadCfg(input logic [CFG_BITS-1:0] v);
      for (int i = CFG_BITS - 1; i >= 0; i--) begin
         shiftBit(v[i]);
      end
      config_enable = 1'b0;
      config_in     = 1'b0;
      #1;
   endtask

   task automatic checkAllZero(input string name);
      checkOutput(name, {18'd0, data_to_io, data_to_ic}, 32'd0);
      checkOutput({name, "_oe"}, {28'd0, data_oe_io}, 32'd0);
   endtask

   logic [CFG_BITS-1:0] cfgA;
   logic [CFG_BITS-1:0] cfgFan;
   logic                expOut;

   initial begin
      checks   = 0;
      failures = 0;

      // Tracks: t0 p0, t1 p1, t2 off, t3 p3, t4 p1, t5 p2, t6 off, t7 p0, t8 p3, t9 p1.
      // Pads: p0 <- ic9 oe comb, p1 <- osel 12 oe comb, p2 <- ic3 reg no oe, in_reg, p3 <- ic0 oe comb.
      cfgA = '0;
      cfgA = setIo(cfgA, 0, 1'b0, 1'b0, 1'b1, 4'd9);
      cfgA = setIo(cfgA, 1, 1'b0, 1'b0, 1'b1, 4'd12);
      cfgA = setIo(cfgA, 2, 1'b1, 1'b1, 1'b0, 4'd3);
      cfgA = setIo(cfgA, 3, 1'b0, 1'b0, 1'b1, 4'd0);
      cfgA = setIc(cfgA, 0, 1'b1, 2'd0);
      cfgA = setIc(cfgA, 1, 1'b1, 2'd1);
      cfgA = setIc(cfgA, 2, 1'b0, 2'd1);
      cfgA = setIc(cfgA, 3, 1'b1, 2'd3);
      cfgA = setIc(cfgA, 4, 1'b1, 2'd1);
      cfgA = setIc(cfgA, 5, 1'b1, 2'd2);
      cfgA = setIc(cfgA, 6, 1'b0, 2'd0);
      cfgA = setIc(cfgA, 7, 1'b1, 2'd0);
      cfgA = setIc(cfgA, 8, 1'b1, 2'd3);
      cfgA = setIc(cfgA, 9, 1'b1, 2'd1);

      cfgFan = '0;
      for (int j = 0; j < 10; j++) begin
         cfgFan = setIc(cfgFan, j, 1'b1, 2'd1);
      end

      vecs[0] = '{4'b0000, 10'h000, 4'b0000, 4'b1011, 10'h000};
      vecs[1] = '{4'b0001, 10'h200, 4'b0001, 4'b1011, 10'h081};
      vecs[2] = '{4'b0010, 10'h008, 4'b0100, 4'b1011, 10'h212};
      vecs[3] = '{4'b0100, 10'h001, 4'b1000, 4'b1011, 10'h020};
      vecs[4] = '{4'b1000, 10'h3FF, 4'b1101, 4'b1011, 10'h108};
      vecs[5] = '{4'b1111, 10'h1F6, 4'b0000, 4'b1011, 10'h3BB};

      // Reset state with active inputs.
      reset         = 1'b1;
      config_enable = 1'b0;
      config_in     = 1'b0;
      applyStimulus(4'hF, 10'h3FF);
      #12;
      checkAllZero("reset_outputs");
      checkOutput("reset_config_out", {31'd0, config_out}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      tick();

      // Chain: 64 alternating bits starting with 1, outputs gated throughout.
      for (int n = 0; n < 64; n++) begin
         shiftBit((n % 2) == 0);
         checkAllZero("shift_gate");
         expOut = (n + 1 >= CFG_BITS) ? (((n + 1 - CFG_BITS) % 2) == 0) : 1'b0;
         checkOutput("chain_delay", {31'd0, config_out}, {31'd0, expOut});
      end
      config_enable = 1'b0;
      for (int n = 0; n < 3; n++) begin
         config_in = n[0];
         tick();
         checkOutput("chain_hold", {31'd0, config_out}, 32'd1);
      end

      // Table-driven steady-state routing with configuration A.
      loadCfg(cfgA);
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].io, vecs[v].ic);
         tick();
         checkOutput($sformatf("vec%0d_to_io", v), {28'd0, data_to_io}, {28'd0, vecs[v].expToIo});
         checkOutput($sformatf("vec%0d_oe", v), {28'd0, data_oe_io}, {28'd0, vecs[v].expOe});
         checkOutput($sformatf("vec%0d_to_ic", v), {22'd0, data_to_ic}, {22'd0, vecs[v].expToIc});
      end

      // Combinational pad path responds within the same cycle.
      applyStimulus(4'b0000, 10'h000);
      tick();
      data_from_ic = 10'h200;
      #1;
      checkOutput("comb_same_cycle", {28'd0, data_to_io}, 32'h1);
      checkOutput("comb_oe", {28'd0, data_oe_io}, 32'hB);

      // Registered pad output lags by one clock.
      applyStimulus(4'b0000, 10'h000);
      tick();
      data_from_ic = 10'h008;
      #1;
      checkOutput("reg_out_before", {28'd0, data_to_io}, 32'h0);
      tick();
      checkOutput("reg_out_after", {28'd0, data_to_io}, 32'h4);

      // Registered input path on track 5 lags pad 2 by one clock.
      applyStimulus(4'b0100, 10'h000);
      #1;
      checkOutput("reg_in_before", {22'd0, data_to_ic}, 32'h000);
      tick();
      checkOutput("reg_in_rise", {22'd0, data_to_ic}, 32'h020);
      data_from_io = 4'b0000;
      #1;
      checkOutput("reg_in_hold", {22'd0, data_to_ic}, 32'h020);
      tick();
      checkOutput("reg_in_fall", {22'd0, data_to_ic}, 32'h000);

      // Reconfiguration gating on a configured tile.
      applyStimulus(4'hF, 10'h3FF);
      tick();
      checkOutput("pre_gate_to_io", {28'd0, data_to_io}, 32'hD);
      checkOutput("pre_gate_to_ic", {22'd0, data_to_ic}, 32'h3BB);
      config_in     = 1'b0;
      config_enable = 1'b1;
      #1;
      checkAllZero("gate_same_cycle");
      loadCfg(cfgA);
      checkOutput("resume_to_io", {28'd0, data_to_io}, 32'h9);
      checkOutput("resume_oe", {28'd0, data_oe_io}, 32'hB);
      checkOutput("resume_to_ic", {22'd0, data_to_ic}, 32'h39B);
      tick();
      checkOutput("resume_reg_to_io", {28'd0, data_to_io}, 32'hD);
      checkOutput("resume_reg_to_ic", {22'd0, data_to_ic}, 32'h3BB);

      // Fan-out: every track follows pad 1.
      loadCfg(cfgFan);
      applyStimulus(4'b0010, 10'h000);
      #1;
      checkOutput("fanout_hi", {22'd0, data_to_ic}, 32'h3FF);
      applyStimulus(4'b1101, 10'h000);
      #1;
      checkOutput("fanout_lo", {22'd0, data_to_ic}, 32'h000);

      // Reset in the middle of a shift discards the partial configuration.
      loadCfg(cfgA);
      for (int n = 0; n < 20; n++) begin
         shiftBit(1'b1);
      end
      #2;
      reset = 1'b1;
      #1;
      checkAllZero("midshift_reset");
      checkOutput("midshift_cfg_out", {31'd0, config_out}, 32'd0);
      @(negedge clock);
      reset         = 1'b0;
      config_enable = 1'b0;
      applyStimulus(4'hF, 10'h3FE);
      #1;
      checkAllZero("after_reset_cleared");
      data_from_ic = 10'h001;
      #1;
      checkOutput("after_reset_osel0", {28'd0, data_to_io}, 32'hF);
      checkOutput("after_reset_cfg_out", {31'd0, config_out}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
